// File: rtl/level_peak_hold_if.sv
// rtl/level_peak_hold_if.sv - min/max pair input and meter level output handshake bundle
interface level_peak_hold_if #(
  parameter int width = 16
);
  logic             i_valid;
  logic             i_ready;
  logic [width-1:0] i_min_value;
  logic [width-1:0] i_max_value;
  logic             o_valid;
  logic             o_ready;
  logic [width-1:0] o_level;
  logic             o_clip;

  modport slave (
    input  i_valid, i_min_value, i_max_value, o_ready,
    output i_ready, o_valid, o_level, o_clip
  );

  modport master (
    output i_valid, i_min_value, i_max_value, o_ready,
    input  i_ready, o_valid, o_level, o_clip
  );
endinterface

// File: rtl/level_peak_hold.sv
// rtl/level_peak_hold.sv - peak meter ballistics: instant attack, hold, then linear decay
module level_peak_hold #(
  parameter int               width      = 16,
  parameter int               hold_count = 4,
  parameter logic [width-1:0] decay_step = width'(16'h0100)
) (
  input  logic               clk,
  input  logic               reset,
  level_peak_hold_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, MAG, UPD, OUT} state_t;

  localparam logic [width-1:0] most_neg  = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] most_pos  = {1'b0, {(width-1){1'b1}}};
  localparam logic [7:0]       hold_init = 8'(hold_count);

  state_t           state_q, state_d;
  logic [width-1:0] min_q, min_d;
  logic [width-1:0] max_q, max_d;
  logic [width-1:0] peak_q, peak_d;
  logic [width-1:0] level_q, level_d;
  logic [7:0]       hold_q, hold_d;
  logic             clip_next_q, clip_next_d;
  logic             clip_q, clip_d;

  logic [width-1:0] min_mag, max_mag, level_dec;

  // The most-negative code has no positive counterpart, so it pins to full scale.
  function automatic logic [width-1:0] magnitude(input logic [width-1:0] x);
    if (x == most_neg)
      return most_pos;
    else if (x[width-1])
      return -x;
    else
      return x;
  endfunction

  assign min_mag   = magnitude(min_q);
  assign max_mag   = magnitude(max_q);
  assign level_dec = (level_q >= decay_step) ? (level_q - decay_step) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      min_q       <= '0;
      max_q       <= '0;
      peak_q      <= '0;
      level_q     <= '0;
      hold_q      <= '0;
      clip_next_q <= 1'b0;
      clip_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      max_q       <= max_d;
      peak_q      <= peak_d;
      level_q     <= level_d;
      hold_q      <= hold_d;
      clip_next_q <= clip_next_d;
      clip_q      <= clip_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    max_d       = max_q;
    peak_d      = peak_q;
    level_d     = level_q;
    hold_d      = hold_q;
    clip_next_d = clip_next_q;
    clip_d      = clip_q;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          min_d   = bus.i_min_value;
          max_d   = bus.i_max_value;
          state_d = MAG;
        end
      end
      MAG: begin
        peak_d      = (min_mag > max_mag) ? min_mag : max_mag;
        clip_next_d = (min_q == most_neg) || (max_q == most_pos);
        state_d     = UPD;
      end
      UPD: begin
        // An equal peak counts as fresh and restarts the hold window.
        if (peak_q >= level_q) begin
          level_d = peak_q;
          hold_d  = hold_init;
        end else if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          level_d = (peak_q > level_dec) ? peak_q : level_dec;
        end
        clip_d  = clip_next_q;
        state_d = OUT;
      end
      OUT: begin
        if (bus.o_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.i_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == OUT);
  assign bus.o_level = level_q;
  assign bus.o_clip  = clip_q;

endmodule

// File: tb/tb_level_peak_hold.sv
// tb/tb_level_peak_hold.sv - randomized and directed check of level_peak_hold against a meter model
module tb_level_peak_hold;

  localparam int HOLD  = 2;
  localparam int DECAY = 16'h1000;

  logic clk = 1'b0;
  logic reset = 1'b1;

  level_peak_hold_if #(.width(16)) bus();

  level_peak_hold #(
    .width(16),
    .hold_count(HOLD),
    .decay_step(16'h1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int xfer_count = 0;
  int m_level = 0;
  int m_hold = 0;
  logic [16:0] exp_q[$];
  logic [15:0] last_level = '0;
  logic        last_clip = 1'b0;
  bit          done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mag(input logic [15:0] x);
    int v = $signed(x);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  // Meter model: one update per accepted pair, result queued in order.
  task automatic model_push(input logic [15:0] mn, input logic [15:0] mx);
    int pk;
    bit clip;
    pk = (mag(mn) > mag(mx)) ? mag(mn) : mag(mx);
    clip = ($signed(mn) == -32768) || ($signed(mx) == 32767);
    if (pk >= m_level) begin
      m_level = pk;
      m_hold = HOLD;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      m_level = m_level - DECAY;
      if (m_level < 0) m_level = 0;
      if (pk > m_level) m_level = pk;
    end
    exp_q.push_back({clip, 16'(m_level)});
  endtask

  task automatic model_clear();
    m_level = 0;
    m_hold = 0;
    exp_q.delete();
    last_level = '0;
    last_clip = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.o_valid) begin
        chk("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("level", bus.o_level, exp_q[0][15:0]);
          chk("clip", bus.o_clip, exp_q[0][16]);
          if (bus.o_ready) begin
            last_level = exp_q[0][15:0];
            last_clip = exp_q[0][16];
            void'(exp_q.pop_front());
            xfer_count++;
          end
        end
      end else begin
        chk("idle_level", bus.o_level, last_level);
        chk("idle_clip", bus.o_clip, last_clip);
      end
    end
  end

  task automatic send(input logic [15:0] mn, input logic [15:0] mx);
    int g = 0;
    while (!bus.i_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    chk("send_ready", bus.i_ready, 1);
    if (bus.i_ready) begin
      bus.i_valid = 1'b1;
      bus.i_min_value = mn;
      bus.i_max_value = mx;
      @(posedge clk);
      model_push(mn, mx);
      #1;
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input string name, input logic [15:0] lvl, input logic clp);
    int g = 0;
    while (!bus.o_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_valid"}, bus.o_valid, 1);
    chk({name, "_level"}, bus.o_level, lvl);
    chk({name, "_clip"}, bus.o_clip, clp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_valid = 1'b0;
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int xfer0;
    logic [15:0] mn, mx;

    bus.i_valid = 1'b0;
    bus.i_min_value = '0;
    bus.i_max_value = '0;
    bus.o_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_i_ready", bus.i_ready, 1);
    chk("rst_o_valid", bus.o_valid, 0);
    chk("rst_o_level", bus.o_level, 16'h0000);
    chk("rst_o_clip", bus.o_clip, 0);

    send(16'hEEEF, 16'h1111);
    chk("lat_n1", bus.o_valid, 0);
    @(posedge clk); #1;
    chk("lat_n2_pre", bus.o_valid, 0);
    @(posedge clk); #1;
    chk("lat_n2", bus.o_valid, 1);
    wait_out("p1", 16'h1111, 1'b0);

    send(16'h8000, 16'h0000); wait_out("negfs", 16'h7FFF, 1'b1);
    send(16'h8001, 16'h7FFE); wait_out("nearfs", 16'h7FFF, 1'b0);
    send(16'hFF00, 16'h0100); wait_out("hold1", 16'h7FFF, 1'b0);
    send(16'hFF00, 16'h0100); wait_out("hold2", 16'h7FFF, 1'b0);
    send(16'hFF00, 16'h0100); wait_out("decay1", 16'h6FFF, 1'b0);

    do_reset();
    send(16'hEEEF, 16'h1111); wait_out("f_peak", 16'h1111, 1'b0);
    send(16'h0000, 16'h0000); wait_out("f_hold1", 16'h1111, 1'b0);
    send(16'h0000, 16'h0000); wait_out("f_hold2", 16'h1111, 1'b0);
    send(16'hFF00, 16'h0100); wait_out("f_dec", 16'h0111, 1'b0);
    send(16'hFF00, 16'h0100); wait_out("f_floor", 16'h0100, 1'b0);

    // Backpressure: result must sit still while extra inputs are ignored.
    bus.o_ready = 1'b0;
    send(16'hC000, 16'h2000);
    g = 0;
    while (!bus.o_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    chk("bp_valid", bus.o_valid, 1);
    for (int k = 0; k < 5; k++) begin
      bus.i_valid = k[0];
      bus.i_min_value = 16'h8000;
      bus.i_max_value = 16'h7FFF;
      @(posedge clk); #1;
      chk("bp_valid_hold", bus.o_valid, 1);
      chk("bp_level_hold", bus.o_level, 16'h4000);
      chk("bp_i_ready", bus.i_ready, 0);
    end
    bus.i_valid = 1'b0;
    xfer0 = xfer_count;
    bus.o_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_one_xfer", xfer_count - xfer0, 1);

    bus.i_valid = 1'b1;
    bus.i_min_value = 16'h8000;
    bus.i_max_value = 16'h7FFF;
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    chk("mag_busy", bus.i_ready, 0);
    xfer0 = xfer_count;
    reset = 1'b1;
    #1;
    chk("rmag_o_valid", bus.o_valid, 0);
    chk("rmag_o_level", bus.o_level, 16'h0000);
    chk("rmag_o_clip", bus.o_clip, 0);
    chk("rmag_i_ready", bus.i_ready, 1);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rmag_no_output", xfer_count - xfer0, 0);

    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          mn = 16'($urandom);
          mx = 16'($urandom);
          case ($urandom_range(0, 5))
            0: mn = 16'h8000;
            1: mx = 16'h7FFF;
            2: begin
              mn = -16'($urandom_range(0, 600));
              mx = 16'($urandom_range(0, 600));
            end
            3: begin
              mn = 16'h0000;
              mx = 16'h0000;
            end
            default: ;
          endcase
          send(mn, mx);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.o_ready = ($urandom_range(0, 3) != 0);
        end
        bus.o_ready = 1'b1;
      end
    join

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
